// File: rtl/store_buffer.sv
// Circular store queue between execute and data memory: captures speculative stores,
// commits them in ROB order, drains committed stores one per handshake, forwards to loads.
module store_buffer #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              full_o,
  input  logic              commit_i,
  input  logic              kill_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic              load_hit_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ready_i,
  output logic [PTR_W:0]    count_o,
  output logic              overflow_o
);

  localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

  // Pointers carry a wrap bit above the index so full and empty are distinguishable.
  logic [PTR_W:0]    head_q, cmt_q, tail_q;
  logic [PTR_W:0]    cmt_next;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic drain, commit_fire, alloc;
  logic [PTR_W-1:0] fwd_idx;

  assign count_o  = tail_q - head_q;
  assign full_o   = (head_q[PTR_W-1:0] == tail_q[PTR_W-1:0]) && (head_q[PTR_W] != tail_q[PTR_W]);
  assign mem_we_o = (head_q != cmt_q);
  assign mem_addr_o = mem_we_o ? addr_q[head_q[PTR_W-1:0]] : '0;
  assign mem_data_o = mem_we_o ? data_q[head_q[PTR_W-1:0]] : '0;

  assign drain       = mem_we_o && mem_ready_i;
  assign commit_fire = commit_i && (cmt_q != tail_q);
  assign alloc       = we_i && !full_o && !kill_i;
  assign cmt_next    = commit_fire ? cmt_q + PTR_ONE : cmt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q     <= '0;
      cmt_q      <= '0;
      tail_q     <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (drain) head_q <= head_q + PTR_ONE;
      cmt_q <= cmt_next;
      // A kill rolls tail back to the post-commit boundary, so a store retiring this cycle survives.
      if (kill_i)     tail_q <= cmt_next;
      else if (alloc) tail_q <= tail_q + PTR_ONE;
      if (we_i && full_o && !kill_i) overflow_o <= 1'b1;
    end
  end

  // NOTE: entry storage has no reset; liveness comes only from the pointers, so stale
  // contents are never observable and the array can map onto plain RAM/flops without reset.
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      addr_q[tail_q[PTR_W-1:0]] <= waddr_i;
      data_q[tail_q[PTR_W-1:0]] <= wdata_i;
    end
  end

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    // NOTE: every combinational output gets a default before the loop; otherwise a
    // path with no match would hold its old value and infer a latch.
    load_hit_o  = 1'b0;
    load_data_o = '0;
    fwd_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      // NOTE: blocking assignments here, since fwd_idx must be visible within the same
      // iteration; sequential state elsewhere uses non-blocking.
      fwd_idx = head_q[PTR_W-1:0] + PTR_W'(i);
      if (((PTR_W+1)'(i) < count_o) && (addr_q[fwd_idx] == load_addr_i)) begin
        load_hit_o  = 1'b1;
        load_data_o = data_q[fwd_idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed vector table, corner-case sequences and
// randomized traffic compared against a queue-based reference model.
module tb_store_buffer;

  logic        clk_i = 1'b0;
  logic        reset_i, we_i, commit_i, kill_i, mem_ready_i;
  logic [31:0] waddr_i, wdata_i, load_addr_i;
  logic        full_o, load_hit_o, mem_we_o, overflow_o;
  logic [31:0] load_data_o, mem_addr_o, mem_data_o;
  logic [3:0]  count_o;

  int checks = 0;
  int errors = 0;

  store_buffer dut (
    .clk_i(clk_i), .reset_i(reset_i), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .full_o(full_o), .commit_i(commit_i), .kill_i(kill_i), .load_addr_i(load_addr_i),
    .load_hit_o(load_hit_o), .load_data_o(load_data_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i),
    .count_o(count_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: program-order list of live stores, each flagged committed or not.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          committed;
  } ent_t;
  ent_t q[$];
  bit   m_ovf = 0;

  typedef struct {
    logic        we;
    logic [31:0] wa, wd;
    logic        cm, kl, rdy;
    logic [31:0] la;
    int          e_count;
    logic        e_full, e_mwe;
    logic [31:0] e_maddr, e_mdata;
    logic        e_hit;
    logic [31:0] e_ldata;
  } vec_t;
  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic cm, input logic kl, input logic rdy, input logic [31:0] la);
    reset_i = rst; we_i = we; waddr_i = wa; wdata_i = wd;
    commit_i = cm; kill_i = kl; mem_ready_i = rdy; load_addr_i = la;
  endtask

  task automatic compare_model();
    bit          hit = 0;
    logic [31:0] ld = '0;
    bit          mwe = (q.size() > 0) && q[0].committed;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].addr == load_addr_i) begin hit = 1; ld = q[i].data; break; end
    check("m_count",    32'(count_o),   32'(q.size()));
    check("m_full",     32'(full_o),    32'(q.size() == 8));
    check("m_mem_we",   32'(mem_we_o),  32'(mwe));
    check("m_mem_addr", mem_addr_o,     mwe ? q[0].addr : 32'h0);
    check("m_mem_data", mem_data_o,     mwe ? q[0].data : 32'h0);
    check("m_hit",      32'(load_hit_o), 32'(hit));
    check("m_ldata",    load_data_o,    ld);
    check("m_overflow", 32'(overflow_o), 32'(m_ovf));
  endtask

  task automatic step_model();
    bit full, mwe;
    ent_t e;
    if (reset_i) begin
      q.delete();
      m_ovf = 0;
      return;
    end
    full = (q.size() == 8);
    mwe  = (q.size() > 0) && q[0].committed;
    if (commit_i)
      for (int i = 0; i < q.size(); i++)
        if (!q[i].committed) begin e = q[i]; e.committed = 1; q[i] = e; break; end
    if (kill_i)
      while (q.size() > 0 && !q[q.size()-1].committed) void'(q.pop_back());
    if (mwe && mem_ready_i) void'(q.pop_front());
    if (we_i && !kill_i) begin
      if (full) m_ovf = 1;
      else begin e.addr = waddr_i; e.data = wdata_i; e.committed = 0; q.push_back(e); end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drive one cycle: check DUT against the model, advance both past the clock edge.
  task automatic apply(input logic rst, input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic cm, input logic kl, input logic rdy, input logic [31:0] la);
    drive(rst, we, wa, wd, cm, kl, rdy, la);
    #1;
    compare_model();
    step_model();
    tick();
  endtask

  initial begin
    //            we  waddr   wdata  cm kl rdy load    cnt full mwe maddr   mdata  hit ldata
    vecs[0]  = '{1, 32'h100, 32'h11, 0, 0, 0, 32'h100, 0, 0, 0, 32'h0,   32'h0,  0, 32'h0};
    vecs[1]  = '{1, 32'h104, 32'h22, 0, 0, 0, 32'h100, 1, 0, 0, 32'h0,   32'h0,  1, 32'h11};
    vecs[2]  = '{1, 32'h108, 32'h33, 0, 0, 0, 32'h104, 2, 0, 0, 32'h0,   32'h0,  1, 32'h22};
    vecs[3]  = '{0, 32'h0,   32'h0,  0, 0, 0, 32'h108, 3, 0, 0, 32'h0,   32'h0,  1, 32'h33};
    vecs[4]  = '{0, 32'h0,   32'h0,  1, 0, 1, 32'h0,   3, 0, 0, 32'h0,   32'h0,  0, 32'h0};
    vecs[5]  = '{0, 32'h0,   32'h0,  1, 0, 1, 32'h0,   3, 0, 1, 32'h100, 32'h11, 0, 32'h0};
    vecs[6]  = '{0, 32'h0,   32'h0,  0, 0, 1, 32'h0,   2, 0, 1, 32'h104, 32'h22, 0, 32'h0};
    vecs[7]  = '{0, 32'h0,   32'h0,  0, 0, 1, 32'h108, 1, 0, 0, 32'h0,   32'h0,  1, 32'h33};
    vecs[8]  = '{1, 32'h200, 32'hAA, 1, 0, 0, 32'h0,   1, 0, 0, 32'h0,   32'h0,  0, 32'h0};
    vecs[9]  = '{1, 32'h200, 32'hBB, 0, 0, 0, 32'h200, 2, 0, 1, 32'h108, 32'h33, 1, 32'hAA};
    vecs[10] = '{0, 32'h0,   32'h0,  0, 0, 0, 32'h200, 3, 0, 1, 32'h108, 32'h33, 1, 32'hBB};
    vecs[11] = '{0, 32'h0,   32'h0,  0, 0, 0, 32'h204, 3, 0, 1, 32'h108, 32'h33, 0, 32'h0};

    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    q.delete();
    m_ovf = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0);
    #1;
    check("rst_count",    32'(count_o),    0);
    check("rst_full",     32'(full_o),     0);
    check("rst_hit",      32'(load_hit_o), 0);
    check("rst_ldata",    load_data_o,     0);
    check("rst_mem_we",   32'(mem_we_o),   0);
    check("rst_mem_addr", mem_addr_o,      0);
    check("rst_mem_data", mem_data_o,      0);
    check("rst_overflow", 32'(overflow_o), 0);
    tick();

    // Directed vector table: alloc, in-order drain, youngest-match forwarding
    for (int i = 0; i < 12; i++) begin
      drive(0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].cm, vecs[i].kl, vecs[i].rdy, vecs[i].la);
      #1;
      check($sformatf("v%0d_count", i),    32'(count_o),    32'(vecs[i].e_count));
      check($sformatf("v%0d_full", i),     32'(full_o),     32'(vecs[i].e_full));
      check($sformatf("v%0d_mem_we", i),   32'(mem_we_o),   32'(vecs[i].e_mwe));
      check($sformatf("v%0d_mem_addr", i), mem_addr_o,      vecs[i].e_maddr);
      check($sformatf("v%0d_mem_data", i), mem_data_o,      vecs[i].e_mdata);
      check($sformatf("v%0d_hit", i),      32'(load_hit_o), 32'(vecs[i].e_hit));
      check($sformatf("v%0d_ldata", i),    load_data_o,     vecs[i].e_ldata);
      compare_model();
      step_model();
      tick();
    end

    // Fill, overflow, same-cycle drain does not free a slot, wrap-around alloc
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) apply(0, 1, 32'h300 + 32'(4*i), 32'(i+1), 0, 0, 0, 0);
    check("fill_full", 32'(full_o), 1);
    apply(0, 1, 32'h3F0, 32'hEE, 0, 0, 0, 0);
    check("ovf_set",   32'(overflow_o), 1);
    check("ovf_count", 32'(count_o), 8);
    apply(0, 0, 0, 0, 1, 0, 1, 0);
    apply(0, 1, 32'h3F4, 32'hDD, 0, 0, 1, 0);
    check("drain_count", 32'(count_o), 7);
    check("drain_full",  32'(full_o), 0);
    apply(0, 1, 32'h3F8, 32'hCC, 0, 0, 0, 0);
    check("wrap_count", 32'(count_o), 8);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h3F8);
    check("wrap_hit",   32'(load_hit_o), 1);
    check("wrap_ldata", load_data_o, 32'hCC);

    // Kill with same-cycle commit: committed entries survive and drain in order
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(0, 1, 32'h400 + 32'(4*i), 32'h50 + 32'(i), 0, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 0, 0, 0, 1, 0, 0, 0);
    apply(0, 1, 32'h4F0, 32'h99, 1, 1, 0, 0);
    check("kill_count", 32'(count_o), 3);
    check("kill_ovf",   32'(overflow_o), 0);
    apply(0, 0, 0, 0, 0, 0, 0, 32'h40C);
    check("kill_fwd_miss", 32'(load_hit_o), 0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 0, 0, 1, 32'h408);
    check("kill_drained", 32'(count_o), 0);

    // Reset mid-operation discards committed entries without a memory write
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) apply(0, 1, 32'h600 + 32'(4*i), 32'h70 + 32'(i), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) apply(0, 0, 0, 0, 1, 0, 0, 0);
    check("pre_rst_mem_we", 32'(mem_we_o), 1);
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    check("mid_rst_count",  32'(count_o), 0);
    check("mid_rst_mem_we", 32'(mem_we_o), 0);
    check("mid_rst_ovf",    32'(overflow_o), 0);
    apply(0, 0, 0, 0, 0, 0, 1, 32'h600);

    // Randomized traffic against the reference model
    apply(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 99) == 0),
            ($urandom_range(0, 99) < 55),
            32'h500 + 32'(4 * $urandom_range(0, 7)),
            $urandom(),
            ($urandom_range(0, 99) < 40),
            ($urandom_range(0, 99) < 5),
            ($urandom_range(0, 99) < 45),
            32'h500 + 32'(4 * $urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
